// File: rtl/noc_stream_checker.sv
`default_nettype none
// ============================================================================
// Module   : noc_stream_checker
// Purpose  : In-line monitor for one NoC val/rdy channel. Parses msg_len from
//            each header flit, tracks the body flits and flags framing and
//            handshake violations. Flits pass through with zero latency and
//            are never modified or dropped.
// Ports    : clk, rst_n (async active-low)
//            src_chk_noc_val / src_chk_noc_data / chk_src_noc_rdy : upstream
//            chk_dst_noc_val / chk_dst_noc_data / dst_chk_noc_rdy : downstream
//            clr_stats  : synchronous clear of counters and sticky bits
//            err_sticky : [0] length, [1] stability, [2] timeout
//            err_pulse  : one-cycle pulse for every cycle with an error
//            pkt_cnt    : completed packets (saturating)
//            err_cnt    : detected errors (saturating)
//            in_pkt     : high while tracking body flits
// Config   : NOC_STREAM_CHECKER_TIMEOUT_EN builds the stall watchdog; without
//            it err_sticky[2] is tied low and BODY is held indefinitely.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif

module noc_stream_checker #(
    parameter int NOC_DATA_WIDTH = `NOC_DATA_WIDTH,
    parameter int MSG_LEN_LSB    = 0,
    parameter int MSG_LEN_W      = 8,
    parameter int MAX_MSG_LEN    = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      src_chk_noc_val,
    input  logic [NOC_DATA_WIDTH-1:0] src_chk_noc_data,
    output logic                      chk_src_noc_rdy,
    output logic                      chk_dst_noc_val,
    output logic [NOC_DATA_WIDTH-1:0] chk_dst_noc_data,
    input  logic                      dst_chk_noc_rdy,
    input  logic                      clr_stats,
    output logic [2:0]                err_sticky,
    output logic                      err_pulse,
    output logic [31:0]               pkt_cnt,
    output logic [15:0]               err_cnt,
    output logic                      in_pkt
);

    localparam logic [0:0] S_HDR  = 1'b0;
    localparam logic [0:0] S_BODY = 1'b1;

    // Pure wires on the data path: no added latency.
    assign chk_dst_noc_val  = src_chk_noc_val;
    assign chk_dst_noc_data = src_chk_noc_data;
    assign chk_src_noc_rdy  = dst_chk_noc_rdy;

    logic [0:0]                r_state;
    logic [MSG_LEN_W-1:0]      r_remain;
    logic                      r_stall_prev;
    logic [NOC_DATA_WIDTH-1:0] r_data_prev;
    logic [2:0]                r_sticky;
    logic                      r_pulse;
    logic [31:0]               r_pkt_cnt;
    logic [15:0]               r_err_cnt;

    logic                      w_hs;
    logic                      w_hdr_hs;
    logic                      w_body_hs;
    logic [MSG_LEN_W-1:0]      w_len;
    logic                      w_len_err;
    logic                      w_stab_err;
    logic                      w_timeout;
    logic                      w_pkt_done;
    logic [1:0]                w_n_err;
    logic [2:0]                w_sticky_base;
    logic [31:0]               w_pkt_base;
    logic [15:0]               w_err_base;
    logic [16:0]               w_err_sum;

    always_comb begin
        w_hs       = src_chk_noc_val & dst_chk_noc_rdy;
        w_hdr_hs   = (r_state == S_HDR)  & w_hs;
        w_body_hs  = (r_state == S_BODY) & w_hs;
        w_len      = src_chk_noc_data[MSG_LEN_LSB +: MSG_LEN_W];
        w_len_err  = w_hdr_hs & (32'(w_len) > 32'(MAX_MSG_LEN));
        // A flit offered but not taken must be re-offered unchanged.
        w_stab_err = r_stall_prev &
                     (~src_chk_noc_val | (src_chk_noc_data != r_data_prev));
        w_pkt_done = (w_hdr_hs & (w_len == '0)) |
                     (w_body_hs & (r_remain == MSG_LEN_W'(1)));
    end

`ifdef NOC_STREAM_CHECKER_TIMEOUT_EN
    localparam int              C_STALL_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Fires on the stall cycle whose increment would reach TIMEOUT_CYCLES-1.
    localparam logic [C_STALL_W-1:0] C_STALL_LIM = C_STALL_W'(TIMEOUT_CYCLES - 2);

    logic [C_STALL_W-1:0] r_stall_cnt;

    assign w_timeout = (r_state == S_BODY) & ~w_hs & (r_stall_cnt == C_STALL_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_hs || (r_state == S_HDR) || w_timeout) begin
            r_stall_cnt <= '0;
        end else begin
            r_stall_cnt <= r_stall_cnt + C_STALL_W'(1);
        end
    end
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES >= 2);
    assign w_timeout            = 1'b0;
`endif

    always_comb begin
        w_n_err       = 2'(w_len_err) + 2'(w_stab_err) + 2'(w_timeout);
        // Clear first, then let same-cycle events land on the cleared value.
        w_sticky_base = clr_stats ? 3'b000 : r_sticky;
        w_pkt_base    = clr_stats ? 32'd0  : r_pkt_cnt;
        w_err_base    = clr_stats ? 16'd0  : r_err_cnt;
        w_err_sum     = {1'b0, w_err_base} + 17'(w_n_err);
    end

    // Framing state machine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_HDR;
            r_remain <= '0;
        end else if (w_hdr_hs) begin
            // Oversized lengths are still tracked so framing stays aligned.
            if (w_len != '0) begin
                r_state  <= S_BODY;
                r_remain <= w_len;
            end
        end else if (w_body_hs) begin
            r_remain <= r_remain - MSG_LEN_W'(1);
            if (r_remain == MSG_LEN_W'(1)) begin
                r_state <= S_HDR;
            end
        end else if (w_timeout) begin
            // Resync: the next flit is treated as a header.
            r_state  <= S_HDR;
            r_remain <= '0;
        end
    end

    // Stability history and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_prev <= 1'b0;
            r_data_prev  <= '0;
            r_sticky     <= 3'b000;
            r_pulse      <= 1'b0;
            r_pkt_cnt    <= 32'd0;
            r_err_cnt    <= 16'd0;
        end else begin
            r_stall_prev <= src_chk_noc_val & ~dst_chk_noc_rdy;
            r_data_prev  <= src_chk_noc_data;
            r_sticky     <= w_sticky_base | {w_timeout, w_stab_err, w_len_err};
            r_pulse      <= (w_n_err != 2'd0);
            if (w_pkt_done && (w_pkt_base != 32'hFFFF_FFFF)) begin
                r_pkt_cnt <= w_pkt_base + 32'd1;
            end else begin
                r_pkt_cnt <= w_pkt_base;
            end
            r_err_cnt <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
        end
    end

    assign err_sticky = r_sticky;
    assign err_pulse  = r_pulse;
    assign pkt_cnt    = r_pkt_cnt;
    assign err_cnt    = r_err_cnt;
    assign in_pkt     = (r_state == S_BODY);

endmodule

`default_nettype wire

// File: tb/tb_noc_stream_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_stream_checker
// Purpose  : Self-checking bench for noc_stream_checker. A table of directed
//            vectors covers the basic framing and stability cases; hand-written
//            sequences cover long packets, the stall watchdog, double errors
//            in one cycle and reset mid-packet.
// Revision : 1.0 - initial release
// ============================================================================
module tb_noc_stream_checker;

    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          src_val;
    logic [DW-1:0] src_data;
    logic          src_rdy;
    logic          dst_val;
    logic [DW-1:0] dst_data;
    logic          dst_rdy;
    logic          clr;
    logic [2:0]    sticky;
    logic          pulse;
    logic [31:0]   pkts;
    logic [15:0]   errs;
    logic          inpkt;

    int checks   = 0;
    int failures = 0;

    noc_stream_checker #(
        .NOC_DATA_WIDTH (DW),
        .MSG_LEN_LSB    (0),
        .MSG_LEN_W      (8),
        .MAX_MSG_LEN    (64),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .src_chk_noc_val  (src_val),
        .src_chk_noc_data (src_data),
        .chk_src_noc_rdy  (src_rdy),
        .chk_dst_noc_val  (dst_val),
        .chk_dst_noc_data (dst_data),
        .dst_chk_noc_rdy  (dst_rdy),
        .clr_stats        (clr),
        .err_sticky       (sticky),
        .err_pulse        (pulse),
        .pkt_cnt          (pkts),
        .err_cnt          (errs),
        .in_pkt           (inpkt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        val;
        logic        rdy;
        logic        clr;
        logic [31:0] data;
        logic        in_pkt;
        logic [31:0] pkt;
        logic [15:0] err;
        logic [2:0]  sticky;
        logic        pulse;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_status(input string tag, input logic ip, input logic [31:0] p,
                              input logic [15:0] e, input logic [2:0] s, input logic pl);
        chk({tag, ".in_pkt"},     32'(inpkt),  32'(ip));
        chk({tag, ".pkt_cnt"},    pkts,        p);
        chk({tag, ".err_cnt"},    32'(errs),   32'(e));
        chk({tag, ".err_sticky"}, 32'(sticky), 32'(s));
        chk({tag, ".err_pulse"},  32'(pulse),  32'(pl));
    endtask

    // Apply inputs for one cycle, check the pass-through, then advance to
    // just after the clock edge so the registered outputs can be sampled.
    task automatic drive(input logic v, input logic r, input logic c, input logic [31:0] d);
        src_val  = v;
        dst_rdy  = r;
        clr      = c;
        src_data = d;
        #1;
        chk("pass.val",  32'(dst_val), 32'(v));
        chk("pass.rdy",  32'(src_rdy), 32'(r));
        chk("pass.data", dst_data,     d);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] e_to;
        logic [2:0]  s_to;

        //               val  rdy  clr  data    in   pkt  err  sticky  pulse
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 0, 0, 3'b000, 1'b0}; // idle
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h03, 1'b1, 0, 0, 3'b000, 1'b0}; // hdr len 3
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'hF0, 1'b1, 0, 0, 3'b000, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'hF1, 1'b1, 0, 0, 3'b000, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'hF2, 1'b0, 1, 0, 3'b000, 1'b0}; // last body
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 2, 0, 3'b000, 1'b0}; // hdr len 0
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h02, 1'b1, 2, 0, 3'b000, 1'b0}; // hdr len 2
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h55, 1'b1, 2, 0, 3'b000, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h66, 1'b0, 3, 0, 3'b000, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h0A, 1'b0, 3, 0, 3'b000, 1'b0}; // stalled offer
        vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h0B, 1'b0, 3, 1, 3'b010, 1'b1}; // data changed
        vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 3, 2, 3'b010, 1'b1}; // val dropped
        vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 3, 2, 3'b010, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 32'h46, 1'b1, 0, 1, 3'b001, 1'b1}; // clr + len 70

        rst_n    = 1'b0;
        src_val  = 1'b0;
        dst_rdy  = 1'b1;
        clr      = 1'b0;
        src_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_status("reset", 1'b0, 0, 0, 3'b000, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].val, vecs[i].rdy, vecs[i].clr, vecs[i].data);
            chk_status($sformatf("vec%0d", i), vecs[i].in_pkt, vecs[i].pkt,
                       vecs[i].err, vecs[i].sticky, vecs[i].pulse);
        end

        // Oversized packet: all 70 body flits are tracked.
        for (int i = 0; i < 70; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'(i));
            chk($sformatf("long.in_pkt%0d", i), 32'(inpkt), 32'(i < 69));
            if (i == 0) chk("long.pulse_once", 32'(pulse), 32'd0);
        end
        chk_status("long_end", 1'b0, 1, 1, 3'b001, 1'b0);

        // Stall inside a packet: header len 4 (with clear), one body flit.
        drive(1'b1, 1'b1, 1'b1, 32'h04);
        chk_status("to_hdr", 1'b1, 0, 0, 3'b000, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 32'h00);
        for (int k = 0; k < 14; k++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h00);
        end
        chk_status("to_pre", 1'b1, 0, 0, 3'b000, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 32'h00);
`ifdef NOC_STREAM_CHECKER_TIMEOUT_EN
        chk_status("to_fire", 1'b0, 0, 1, 3'b100, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 32'h00);   // resynced: parsed as a header
        chk_status("to_resync", 1'b0, 1, 1, 3'b100, 1'b0);
        e_to = 16'd1;
        s_to = 3'b100;
`else
        chk_status("to_none", 1'b1, 0, 0, 3'b000, 1'b0);
        for (int k = 0; k < 20; k++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h00);
        end
        chk_status("to_held", 1'b1, 0, 0, 3'b000, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h00);
        end
        chk_status("to_finish", 1'b0, 1, 0, 3'b000, 1'b0);
        e_to = 16'd0;
        s_to = 3'b000;
`endif

        // Stability and length errors in the same cycle: +2, single pulse.
        drive(1'b1, 1'b0, 1'b0, 32'h50);
        chk_status("dbl_pre", 1'b0, 1, e_to, s_to, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 32'h51);
        chk_status("dbl", 1'b1, 1, e_to + 16'd2, s_to | 3'b011, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 32'h00);
        chk_status("dbl_body", 1'b1, 1, e_to + 16'd2, s_to | 3'b011, 1'b0);

        // Asynchronous reset in the middle of BODY.
        src_val = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_status("rst_mid", 1'b0, 0, 0, 3'b000, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h00);   // first flit after reset is a header
        chk_status("post_rst", 1'b0, 1, 0, 3'b000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
